// File: rtl/bsg_acm_ctrl.sv
// bsg_acm_ctrl: sequencer for one Arnold cat map cell array.
// It captures an image and an iteration count, loads the image into the
// array, and pulses the array enable once per transform. It then holds the
// scrambled image on a valid/ready output until the image is taken.
// Optional build macro BSG_ACM_CTRL_PERIOD_MOD_EN reduces the iteration count
// modulo period_p at capture. The map is periodic, so the result is unchanged.
module bsg_acm_ctrl #(
  parameter int board_width_p = 8,
  parameter int iter_width_p  = 8,
  parameter int period_p      = 6
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  input  logic [board_width_p*board_width_p-1:0] data_i,
  input  logic [iter_width_p-1:0]                iters_i,
  output logic [board_width_p*board_width_p-1:0] array_data_o,
  output logic                                   array_update_o,
  output logic                                   array_en_o,
  input  logic [board_width_p*board_width_p-1:0] array_data_i,
  output logic                                   v_o,
  output logic [board_width_p*board_width_p-1:0] data_o,
  input  logic                                   ready_i,
  output logic                                   busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [iter_width_p-1:0] lp_one  = iter_width_p'(32'd1);
  localparam logic [iter_width_p-1:0] lp_zero = iter_width_p'(32'd0);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [iter_width_p-1:0] r_cnt;
  logic [iter_width_p-1:0] w_cnt_next;
  logic [iter_width_p-1:0] w_iters_eff;

`ifdef BSG_ACM_CTRL_PERIOD_MOD_EN
  localparam logic [iter_width_p-1:0] lp_period = iter_width_p'(period_p);
  // Fold the requested count into one map period; a multiple of the period
  // yields zero and the job skips straight to DONE.
  assign w_iters_eff = iters_i % lp_period;
`else
  // Use the requested count as given.
  assign w_iters_eff = iters_i;
`endif

  // Image path: the array is loaded straight from the input, and the result
  // is the array's own output with no extra register, so it holds steady
  // while the array is idle in DONE.
  assign array_data_o = data_i;
  assign data_o       = array_data_i;

  // Next-state, counter update and handshake/array controls.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    ready_o        = 1'b0;
    v_o            = 1'b0;
    array_en_o     = 1'b0;
    array_update_o = 1'b0;
    busy_o         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          array_update_o = 1'b1;
          w_cnt_next     = w_iters_eff;
          if (w_iters_eff != lp_zero) begin
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_DONE;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        busy_o     = 1'b1;
        array_en_o = 1'b1;
        w_cnt_next = r_cnt - lp_one;
        // Leave on the last pass so the counter stops at zero, never below.
        if (r_cnt == lp_one) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_DONE: begin
        busy_o = 1'b1;
        v_o    = 1'b1;
        if (ready_i) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_DONE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = lp_zero;
      end
    endcase
    // Reset silences every control at once, so an aborted job produces no
    // further enable pulses and no result.
    if (reset_i) begin
      ready_o        = 1'b0;
      v_o            = 1'b0;
      array_en_o     = 1'b0;
      array_update_o = 1'b0;
      busy_o         = 1'b0;
    end else begin
      busy_o = busy_o;
    end
  end

  // State and iteration counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= lp_zero;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

endmodule
